// File: rtl/switch_irq_controller.sv
// switch_irq_controller: bus-attached front end for a bank of debouncer channels.
// Provides the shared scan tick, per-channel IRQ enables and clear pulses,
// a small register file and one merged, registered CPU interrupt line.
// Optional build macro: SWITCH_IRQ_READ_CLEAR_EN (reads of the pending
// registers also clear the bits that read as 1).
module switch_irq_controller #(
    parameter int unsigned NR_OF_SWITCHES       = 8,
    parameter logic [15:0] DEFAULT_SCAN_DIVIDER = 16'd49999
) (
    input  logic                      clock,
    input  logic                      nReset,
    input  logic [2:0]                address,
    input  logic                      writeEnable,
    input  logic                      readEnable,
    input  logic [31:0]               dataIn,
    output logic [31:0]               dataOut,
    output logic                      irq,
    output logic                      scanTick,
    output logic [NR_OF_SWITCHES-1:0] enablePressIrq,
    output logic [NR_OF_SWITCHES-1:0] enableReleaseIrq,
    output logic [NR_OF_SWITCHES-1:0] resetPressIrq,
    output logic [NR_OF_SWITCHES-1:0] resetReleaseIrq,
    input  logic [NR_OF_SWITCHES-1:0] pressIrq,
    input  logic [NR_OF_SWITCHES-1:0] releasIrq,
    input  logic [NR_OF_SWITCHES-1:0] currentState
);

    localparam logic [2:0] ADDR_STATE       = 3'd0;
    localparam logic [2:0] ADDR_PRESS_PEND  = 3'd1;
    localparam logic [2:0] ADDR_RELEASE_PEND= 3'd2;
    localparam logic [2:0] ADDR_PRESS_EN    = 3'd3;
    localparam logic [2:0] ADDR_RELEASE_EN  = 3'd4;
    localparam logic [2:0] ADDR_PRESS_CLR   = 3'd5;
    localparam logic [2:0] ADDR_RELEASE_CLR = 3'd6;
    localparam logic [2:0] ADDR_SCAN_DIV    = 3'd7;

    logic [15:0]               scan_div;
    logic [15:0]               tick_cnt;
    logic [31:0]               read_word;
    logic [NR_OF_SWITCHES-1:0] press_clr_next;
    logic [NR_OF_SWITCHES-1:0] release_clr_next;
    logic                      wr_press_en;
    logic                      wr_release_en;
    logic                      wr_press_clr;
    logic                      wr_release_clr;
    logic                      wr_scan_div;
    logic                      unused_data;

    // Data bits above the channel count / divider width are ignored on writes.
    assign unused_data = ^dataIn;

    // Write strobe decode per register.
    always_comb begin
        wr_press_en    = writeEnable && (address == ADDR_PRESS_EN);
        wr_release_en  = writeEnable && (address == ADDR_RELEASE_EN);
        wr_press_clr   = writeEnable && (address == ADDR_PRESS_CLR);
        wr_release_clr = writeEnable && (address == ADDR_RELEASE_CLR);
        wr_scan_div    = writeEnable && (address == ADDR_SCAN_DIV);
    end

    // Read mux; channel-wide values are zero-extended to the bus width.
    always_comb begin
        read_word = '0;
        case (address)
            ADDR_STATE:        read_word[NR_OF_SWITCHES-1:0] = currentState;
            ADDR_PRESS_PEND:   read_word[NR_OF_SWITCHES-1:0] = pressIrq;
            ADDR_RELEASE_PEND: read_word[NR_OF_SWITCHES-1:0] = releasIrq;
            ADDR_PRESS_EN:     read_word[NR_OF_SWITCHES-1:0] = enablePressIrq;
            ADDR_RELEASE_EN:   read_word[NR_OF_SWITCHES-1:0] = enableReleaseIrq;
            ADDR_SCAN_DIV:     read_word[15:0]               = scan_div;
            default:           read_word                     = '0;
        endcase
    end

    // Clear pulse sources: write-1-to-clear, optionally OR'ed with read-clear.
    always_comb begin
        press_clr_next   = wr_press_clr   ? dataIn[NR_OF_SWITCHES-1:0] : '0;
        release_clr_next = wr_release_clr ? dataIn[NR_OF_SWITCHES-1:0] : '0;
`ifdef SWITCH_IRQ_READ_CLEAR_EN
        if (readEnable && (address == ADDR_PRESS_PEND))
            press_clr_next = press_clr_next | pressIrq;
        if (readEnable && (address == ADDR_RELEASE_PEND))
            release_clr_next = release_clr_next | releasIrq;
`endif
    end

    // Register file, read data and one-cycle clear pulses.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            dataOut          <= '0;
            enablePressIrq   <= '0;
            enableReleaseIrq <= '0;
            resetPressIrq    <= '0;
            resetReleaseIrq  <= '0;
            scan_div         <= DEFAULT_SCAN_DIVIDER;
        end else begin
            dataOut         <= readEnable ? read_word : '0;
            resetPressIrq   <= press_clr_next;
            resetReleaseIrq <= release_clr_next;
            if (wr_press_en)
                enablePressIrq <= dataIn[NR_OF_SWITCHES-1:0];
            if (wr_release_en)
                enableReleaseIrq <= dataIn[NR_OF_SWITCHES-1:0];
            if (wr_scan_div)
                scan_div <= dataIn[15:0];
        end
    end

    // Scan tick down-counter; a divider write restarts the period.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            tick_cnt <= DEFAULT_SCAN_DIVIDER;
            scanTick <= 1'b0;
        end else if (wr_scan_div) begin
            tick_cnt <= dataIn[15:0];
            scanTick <= 1'b0;
        end else if (tick_cnt == 16'd0) begin
            tick_cnt <= scan_div;
            scanTick <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt - 16'd1;
            scanTick <= 1'b0;
        end
    end

    // Merged interrupt: any pending press or release event on any channel.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset)
            irq <= 1'b0;
        else
            irq <= |(pressIrq | releasIrq);
    end

endmodule

// File: tb/tb_switch_irq_controller.sv
// Bench for switch_irq_controller: stimulus pushes expected read data into a
// scoreboard queue; a negedge monitor pops it and checks the other outputs
// against a cycle-level behavioural model.
module tb_switch_irq_controller;

    localparam int          N   = 8;
    localparam logic [15:0] DEF = 16'd49999;

    logic         clock = 1'b0;
    logic         nReset = 1'b1;
    logic [2:0]   address = '0;
    logic         writeEnable = 1'b0;
    logic         readEnable = 1'b0;
    logic [31:0]  dataIn = '0;
    logic [31:0]  dataOut;
    logic         irq;
    logic         scanTick;
    logic [N-1:0] enablePressIrq, enableReleaseIrq, resetPressIrq, resetReleaseIrq;
    logic [N-1:0] pressIrq = '0;
    logic [N-1:0] releasIrq = '0;
    logic [N-1:0] currentState = '0;

    always #5 clock = ~clock;

    switch_irq_controller #(
        .NR_OF_SWITCHES(N),
        .DEFAULT_SCAN_DIVIDER(DEF)
    ) dut (
        .clock(clock),
        .nReset(nReset),
        .address(address),
        .writeEnable(writeEnable),
        .readEnable(readEnable),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .irq(irq),
        .scanTick(scanTick),
        .enablePressIrq(enablePressIrq),
        .enableReleaseIrq(enableReleaseIrq),
        .resetPressIrq(resetPressIrq),
        .resetReleaseIrq(resetReleaseIrq),
        .pressIrq(pressIrq),
        .releasIrq(releasIrq),
        .currentState(currentState)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];

    // Register contents as seen by the stimulus side (used for read data).
    logic [N-1:0] m_pen = '0;
    logic [N-1:0] m_ren = '0;
    logic [15:0]  m_div = DEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [N-1:0] p,
                                               input logic [N-1:0] r, input logic [N-1:0] s);
        case (a)
            3'd0:    return 32'(s);
            3'd1:    return 32'(p);
            3'd2:    return 32'(r);
            3'd3:    return 32'(m_pen);
            3'd4:    return 32'(m_ren);
            3'd7:    return 32'(m_div);
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: inputs applied just after a rising edge, sampled at the next.
    task automatic drive(input logic we, input logic re, input logic [2:0] a, input logic [31:0] d,
                         input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] s);
        @(posedge clock);
        #1;
        writeEnable  = we;
        readEnable   = re;
        address      = a;
        dataIn       = d;
        pressIrq     = p;
        releasIrq    = r;
        currentState = s;
        if (re)
            sb.push_back(model_read(a, p, r, s));
        if (we) begin
            case (a)
                3'd3: m_pen = d[N-1:0];
                3'd4: m_ren = d[N-1:0];
                3'd7: m_div = d[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            drive(1'b0, 1'b0, 3'd0, 32'd0, pressIrq, releasIrq, currentState);
    endtask

    // Asynchronous reset in the middle of a cycle; any outstanding read is dropped.
    task automatic apply_reset();
        #3;
        nReset = 1'b0;
        writeEnable = 1'b0;
        readEnable = 1'b0;
        address = '0;
        dataIn = '0;
        pressIrq = '0;
        releasIrq = '0;
        currentState = '0;
        sb.delete();
        m_pen = '0;
        m_ren = '0;
        m_div = DEF;
        repeat (3) @(posedge clock);
        #1;
        nReset = 1'b1;
    endtask

    // Whether the most recent rising edge happened with reset released.
    logic edge_live = 1'b0;
    initial forever begin
        @(posedge clock);
        edge_live = nReset;
    end

    // Monitor: compares outputs against effects of the inputs of the previous edge.
    logic         p_we = 1'b0, p_re = 1'b0;
    logic [2:0]   p_addr = '0;
    logic [31:0]  p_din = '0;
    logic [N-1:0] p_press = '0, p_rel = '0;
    int unsigned  k = 0;
    logic [15:0]  mon_div = DEF;
    logic [N-1:0] mon_pen = '0, mon_ren = '0;

    initial forever begin
        logic [N-1:0] exp_pc, exp_rc;
        @(negedge clock);
        if (!nReset || !edge_live) begin
            if (!nReset) begin
                check("rst_dataOut", dataOut, 32'd0);
                check("rst_irq", 32'(irq), 32'd0);
                check("rst_scanTick", 32'(scanTick), 32'd0);
                check("rst_enables", 32'({enablePressIrq, enableReleaseIrq}), 32'd0);
                check("rst_clears", 32'({resetPressIrq, resetReleaseIrq}), 32'd0);
            end
            k = 0;
            mon_div = DEF;
            mon_pen = '0;
            mon_ren = '0;
        end else begin
            if (p_re) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("read_data", dataOut, sb.pop_front());
                end
            end else begin
                check("idle_dataOut", dataOut, 32'd0);
            end
            check("irq", 32'(irq), 32'(|(p_press | p_rel)));
            exp_pc = (p_we && p_addr == 3'd5) ? p_din[N-1:0] : '0;
            exp_rc = (p_we && p_addr == 3'd6) ? p_din[N-1:0] : '0;
`ifdef SWITCH_IRQ_READ_CLEAR_EN
            if (p_re && p_addr == 3'd1) exp_pc = exp_pc | p_press;
            if (p_re && p_addr == 3'd2) exp_rc = exp_rc | p_rel;
`endif
            check("resetPressIrq", 32'(resetPressIrq), 32'(exp_pc));
            check("resetReleaseIrq", 32'(resetReleaseIrq), 32'(exp_rc));
            if (p_we && p_addr == 3'd3) mon_pen = p_din[N-1:0];
            if (p_we && p_addr == 3'd4) mon_ren = p_din[N-1:0];
            check("enablePressIrq", 32'(enablePressIrq), 32'(mon_pen));
            check("enableReleaseIrq", 32'(enableReleaseIrq), 32'(mon_ren));
            if (p_we && p_addr == 3'd7) begin
                mon_div = p_din[15:0];
                k = 0;
            end else begin
                k++;
            end
            check("scanTick", 32'(scanTick), 32'(k > 0 && (k % (32'(mon_div) + 32'd1)) == 0));
        end
        p_we    = writeEnable;
        p_re    = readEnable;
        p_addr  = address;
        p_din   = dataIn;
        p_press = pressIrq;
        p_rel   = releasIrq;
    end

    initial begin
        #2;
        nReset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nReset = 1'b1;

        // Randomized traffic over the whole register map.
        for (int i = 0; i < 400; i++) begin
            logic        we, re;
            logic [2:0]  a;
            logic [31:0] d;
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd7) d = $urandom_range(0, 5);
            drive(we, re, a, d, N'($urandom), N'($urandom), N'($urandom));
        end

        // Reset mid-count with a read in flight, then the full default period.
        drive(1'b0, 1'b1, 3'd7, 32'd0, '0, '0, '0);
        apply_reset();
        idle(50003);
        drive(1'b0, 1'b1, 3'd7, 32'd0, '0, '0, '0);
        drive(1'b0, 1'b1, 3'd3, 32'd0, '0, '0, '0);
        idle(2);

        // Divider 3 gives a tick every 4 clocks; divider 0 ticks continuously.
        drive(1'b1, 1'b0, 3'd7, 32'd3, '0, '0, '0);
        idle(13);
        drive(1'b1, 1'b0, 3'd7, 32'd0, '0, '0, '0);
        idle(5);

        // Enable/status and merged interrupt.
        drive(1'b1, 1'b0, 3'd3, 32'h05, '0, '0, '0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'h04, '0, '0);
        drive(1'b0, 1'b1, 3'd1, 32'd0, 8'h04, '0, '0);
        idle(1);

        // Write-1-to-clear, then the flag drops.
        drive(1'b1, 1'b0, 3'd5, 32'h0C, 8'h04, '0, '0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, '0, '0, '0);
        idle(2);

        // Read/write collision returns the old value; zero clear write does nothing.
        drive(1'b1, 1'b1, 3'd3, 32'hFF, '0, '0, '0);
        drive(1'b0, 1'b1, 3'd3, 32'd0, '0, '0, '0);
        drive(1'b1, 1'b0, 3'd6, 32'd0, '0, '0, '0);
        idle(1);

        // Pending release read (clears on read only in the read-clear build).
        drive(1'b0, 1'b1, 3'd2, 32'd0, '0, 8'h81, 8'h3C);
        drive(1'b0, 1'b1, 3'd0, 32'd0, '0, 8'h81, 8'h3C);
        drive(1'b0, 1'b0, 3'd0, 32'd0, '0, '0, '0);
        idle(3);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
